// File: rtl/karnaugh_sweep_ctrl_if.sv
// Bundle between board control / function block and the sweep sequencer.
interface karnaugh_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       x_in;
  logic       y_in;
  logic       z_in;
  logic [3:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] ones_x;
  logic [4:0] ones_y;
  logic [4:0] ones_z;
  logic [4:0] mism_cnt;
  logic [3:0] rd_addr;
  logic [2:0] rd_data;

  modport master (
    output start, abort, x_in, y_in, z_in, rd_addr,
    input  vec, busy, done, pass, ones_x, ones_y, ones_z, mism_cnt, rd_data
  );

  modport slave (
    input  start, abort, x_in, y_in, z_in, rd_addr,
    output vec, busy, done, pass, ones_x, ones_y, ones_z, mism_cnt, rd_data
  );
endinterface

// File: rtl/karnaugh_sweep_ctrl.sv
// Steps all 16 input codes into the Karnaugh block, captures x/y/z per code,
// and tallies ones-counts and mismatches against golden truth tables.
module karnaugh_sweep_ctrl #(
  parameter int          SETTLE = 1,
  parameter logic [15:0] EXP_X  = 16'hB7C5,
  parameter logic [15:0] EXP_Y  = 16'hDD66,
  parameter logic [15:0] EXP_Z  = 16'hC33C
) (
  input logic clk,
  input logic rst,
  karnaugh_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [3:0]       idx_q;
  logic [3:0]       cnt_q;
  logic [4:0]       ones_x_q, ones_y_q, ones_z_q, mism_q;
  logic             pass_q;
  logic [15:0][2:0] tbl_q;
  logic             launch, capture;
  logic [2:0]       sample, golden;

  assign sample = {bus.x_in, bus.y_in, bus.z_in};
  assign golden = {EXP_X[idx_q], EXP_Y[idx_q], EXP_Z[idx_q]};

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE:
        if (bus.start && !bus.abort) begin
          state_d = S_SETTLE;
          launch  = 1'b1;
        end
      S_SETTLE:
        if (bus.abort)        state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_SAMPLE;
      S_SAMPLE:
        if (bus.abort) state_d = S_IDLE;  // capture for this code is dropped
        else begin
          capture = 1'b1;
          state_d = (idx_q == 4'd15) ? S_DONE : S_SETTLE;
        end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      ones_x_q <= '0;
      ones_y_q <= '0;
      ones_z_q <= '0;
      mism_q   <= '0;
      pass_q   <= 1'b0;
      tbl_q    <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        idx_q    <= '0;
        cnt_q    <= RELOAD;
        ones_x_q <= '0;
        ones_y_q <= '0;
        ones_z_q <= '0;
        mism_q   <= '0;
        pass_q   <= 1'b0;
        tbl_q    <= '0;
      end else if (capture) begin
        tbl_q[idx_q] <= sample;
        ones_x_q     <= ones_x_q + 5'(sample[2]);
        ones_y_q     <= ones_y_q + 5'(sample[1]);
        ones_z_q     <= ones_z_q + 5'(sample[0]);
        mism_q       <= mism_q + 5'(sample != golden);
        // last code leaves idx at 15 so vec holds it through DONE/IDLE
        if (idx_q != 4'd15) begin
          idx_q <= idx_q + 4'd1;
          cnt_q <= RELOAD;
        end
      end else if (state_q == S_SETTLE && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == S_DONE) pass_q <= (mism_q == '0);
    end
  end

  assign bus.vec      = idx_q;
  assign bus.busy     = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.pass     = pass_q;
  assign bus.ones_x   = ones_x_q;
  assign bus.ones_y   = ones_y_q;
  assign bus.ones_z   = ones_z_q;
  assign bus.mism_cnt = mism_q;
  assign bus.rd_data  = tbl_q[bus.rd_addr];

endmodule

// File: doc/karnaugh_sweep_ctrl.md
# karnaugh_sweep_ctrl

Sequencer that exhaustively exercises the 4-input/3-output Karnaugh function block (inputs d,c,b,a; outputs x,y,z). On `start` it steps all 16 input codes, waits a programmable settle time per code, and captures x/y/z into a 16-entry result table. It accumulates per-output ones-counts and a mismatch count against golden truth tables. It sits between the board-level control (buttons/LEDs) and the function block, whose inputs it owns for the whole sweep.

## Interface
- SETTLE, 1: cycles a code is held before sampling; legal 1..15.
- EXP_X, 16'hB7C5: golden x; bit i = expected x for code i, with i = {d,c,b,a}.
- EXP_Y, 16'hDD66: golden y.
- EXP_Z, 16'hC33C: golden z.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level-sampled; begins a sweep when in IDLE.
- abort  in  1  terminates a sweep; returns to IDLE.
- x_in, y_in, z_in  in  1 each  function block outputs.
- vec  out  4  {d,c,b,a} driven to the function block.
- busy  out  1  high in SETTLE/SAMPLE.
- done  out  1  one-cycle pulse at sweep completion.
- pass  out  1  high after a completed sweep with zero mismatches.
- ones_x, ones_y, ones_z  out  5 each  count of 1s captured per output (0..16).
- mism_cnt  out  5  number of codes with any output differing from golden (0..16).
- rd_addr  in  4  result table read index.
- rd_data  out  3  {x,y,z} captured for rd_addr; combinational read.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Registered outputs; vec is the registered code index.
- IDLE: busy=0. With start=1 and abort=0: idx←0, settle counter←SETTLE-1, clear ones_*, mism_cnt, pass, and table. Go to SETTLE.
- SETTLE: vec=idx. Decrement the counter. When it reads 0, go to SAMPLE.
- SAMPLE: vec=idx. At the clock edge: table[idx]←{x_in,y_in,z_in}; ones_* += each bit; mism_cnt += 1 if any bit ≠ EXP_*[idx].
  - If idx==15, go to DONE.
  - Otherwise idx←idx+1, reload the counter, and go to SETTLE.
- DONE: done=1 for this one cycle. pass←(mism_cnt==0). Go to IDLE. vec holds 15 until the next start.
- abort=1 in SETTLE/SAMPLE: next state IDLE. done is not pulsed and pass stays 0. The current SAMPLE capture is discarded. Partial counts and table entries are held and readable.
- abort has priority over start. start while busy or in DONE is ignored (no restart).
- Counters saturate naturally: max 16 increments into 5 bits, so no overflow.
- SETTLE values outside 1..15 are unsupported. Verification uses only 1, 2 and 15.

## Timing
- Reset values: state IDLE; vec=0; busy=0; done=0; pass=0; ones_*=0; mism_cnt=0; table all 0.
- rst mid-sweep: all of the above at the next edge, regardless of state.
- The start-sampling edge is E0. The function block is combinational, so vec=0 is valid from E0.
- Per code: SETTLE cycles in SETTLE plus 1 cycle in SAMPLE, i.e. SETTLE+1 cycles.
- Code i is sampled at edge E(i+1)(SETTLE+1).
- DONE is entered at edge E16(SETTLE+1). For SETTLE=1, done is high during cycle 32–33 after E0.
- pass and final counts are valid from the edge ending DONE. They hold until the next accepted start or rst.
- busy is high from E0 up to the DONE entry. It is 0 during DONE.
- The earliest accepted back-to-back start is the first cycle in IDLE after DONE.

## Test plan
- Golden sweep: SETTLE=1, real function block connected, start pulse.
  - Required: done at cycle 32 after E0, pass=1, ones_x=10, ones_y=10, ones_z=8, mism_cnt=0.
  - rd_addr=7 → rd_data=3'b100; rd_addr=14 → 3'b011.
- Fault injection: force x_in=0 for the whole sweep.
  - Required: ones_x=0, mism_cnt=10, pass=0, done still pulses once.
- Settle timing: SETTLE=15; monitor vec.
  - Required: each code held 16 cycles, vec steps 0→15 in order, done at cycle 256.
  - Bench changes x_in one cycle before the sample edge; the changed value must be captured.
- Abort: assert abort at cycle 10 of a SETTLE=1 sweep.
  - Required: IDLE next cycle, busy=0, no done, pass=0, table entries 0..3 retained.
  - A new start then runs a full clean sweep with pass=1.
- Start/rst interaction: start held high continuously.
  - Required: exactly one sweep per IDLE visit, with the second sweep beginning the cycle after DONE.
  - rst at cycle 20 → all outputs return to reset values at the next edge; a later start sweeps normally.
